lsu_axi_bridge: RTL and testbench
=================================

Name: lsu_axi_bridge

Overview:
- Downstream neighbour of the load/store unit.
- Converts the LSU's single-request interface (re/we, data_pc, data_o, wlen, core_ready) into single-beat AXI4 master read and write transactions on a 64-bit data bus.
- Returns the raw aligned 64-bit read word as data_temp, plus a completion strobe (data_valid).
- One outstanding transaction at a time; sits between the LSU and the data-side AXI interconnect.

Parameters:
- ADDR_W, 32, AXI address width; data_pc[ADDR_W-1:0] is used.
- DATA_W, 64, AXI data width; fixed to 64 for this core.
- AXI_ID, 4'd1, constant ARID/AWID driven on every transaction.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, synchronous, active-high.
- re  in  1  load request, level.
- we  in  1  store request, level (re and we are never both high).
- data_pc  in  64  load/store address; loads arrive already 8-byte aligned.
- data_o  in  64  byte-lane-positioned store data.
- wlen  in  8  store byte strobe.
- core_ready  in  1  LSU can consume the completion this cycle.
- data_temp  out  64  registered read data.
- data_valid  out  1  active-low completion strobe: 0 = transaction result presented this cycle.
- bus_err  out  1  sticky; set on any non-OKAY RRESP/BRESP.
- AXI read address: ar_valid out 1, ar_ready in 1, ar_addr out ADDR_W, ar_id out 4, ar_len out 8, ar_size out 3, ar_burst out 2.
- AXI read data: r_valid in 1, r_ready out 1, r_data in 64, r_resp in 2, r_last in 1.
- AXI write address: aw_valid out 1, aw_ready in 1, aw_addr out ADDR_W, aw_id out 4, aw_len out 8, aw_size out 3, aw_burst out 2.
- AXI write data: w_valid out 1, w_ready in 1, w_data out 64, w_strb out 8, w_last out 1.
- AXI write response: b_valid in 1, b_ready out 1, b_resp in 2.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Constant outputs: ar_len=aw_len=0, ar_size=aw_size=3'b011, burst=INCR, w_last=1.
- IDLE
  - re=1: latch address, go RD_ADDR.
  - else we=1: latch address/data/strobe, go WR_REQ.
  - Request sampled on the clk edge; first valid is asserted the following cycle.
- RD_ADDR
  - ar_valid=1, address stable.
  - On ar_valid & ar_ready, go RD_DATA.
- RD_DATA
  - r_ready=1.
  - On r_valid: capture r_data into data_temp; OR (r_resp!=0) into bus_err; go DONE.
- WR_REQ
  - aw_valid and w_valid asserted together.
  - Independent aw_done/w_done flags; each valid drops after its own handshake.
  - Go WR_RESP when both handshakes are done; same-cycle acceptance of both is allowed.
- WR_RESP
  - b_ready=1.
  - On b_valid: OR (b_resp!=0) into bus_err; go DONE.
- DONE
  - data_valid=0.
  - Leave to IDLE only on core_ready=1; otherwise hold DONE with data_temp stable.
- Minimum latency, zero-wait slave, load: request edge → RD_ADDR → RD_DATA → DONE, so data_valid is low in the 3rd cycle after the request is sampled.
- Back-to-back requests: IDLE resamples re/we one cycle after DONE exits, so the LSU's next request is never confused with the one just completed.
- data_valid=1 in every state except DONE.
- Write responses do not modify data_temp.
- Reset values:
  - state=IDLE, all AXI valid/ready=0, addresses 0.
  - data_temp=0, data_valid=1, bus_err=0, aw_done=w_done=0.
- Reset mid-transaction: return to IDLE on the next edge and drop all valids immediately; the interconnect is reset on the same rst.
- AXI rule: valid is never withdrawn before its handshake, and address/data/strobe are held stable while valid is high.
- Out-of-range or unaligned read addresses are passed through unchanged.

Decomposition:
- Shared package/define file:
  - AXI constants: SIZE_8B=3'b011, BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - State encoding: 3-bit localparams.
  - The 64-bit DATA width define already used core-wide.
- One natural sub-module, axi_wr_channel_ctl: owns the AW/W independent-handshake flags and the WR_REQ→WR_RESP completion condition.
- The read path stays inline.

Test Plan:
- Load, zero-wait slave, data_pc=0x8000_0010, r_data=0x1122334455667788 → ar_addr=0x80000010; data_valid=0 for exactly 1 cycle, 3 cycles after the request; data_temp=0x1122334455667788.
- Store with aw_ready delayed 3 cycles and w_ready immediate, wlen=8'b00001100, data_o=0x0000_0000_ABCD_0000 → w_valid drops after 1 cycle; aw_valid holds 3 cycles stable; b_ready then asserts; one completion strobe.
- Completion while core_ready=0 for 4 cycles → stays in DONE, data_valid held 0 for 4 cycles with data_temp unchanged; exits on the cycle core_ready=1.
- r_resp=2'b10 (SLVERR) on a load → bus_err=1 and remains 1 through subsequent OKAY transactions until rst.
- rst asserted while in RD_DATA with r_valid low → next cycle: state IDLE, r_ready=0, data_valid=1, data_temp=0.
- Back-to-back load then store with re/we changing at the completion edge → exactly one AR and one AW/W; no duplicate transaction issued.

Source files
------------

// File: rtl/lsu_axi_bridge_pkg.sv
// Shared constants and state encoding for the LSU-to-AXI bridge.
package lsu_axi_bridge_pkg;

  // Core-wide data width; the data-side AXI bus is fixed to this.
  localparam int LSU_DATA_W = 64;

  // AXI encodings used on every transaction
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // 3-bit state encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/lsu_axi_bridge_wr_ctl.sv
// AW/W channel handshake tracker: each valid drops after its own handshake,
// and completion fires once both have been accepted (possibly same cycle).
module axi_wr_channel_ctl (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_aw_ready,
  input  logic i_w_ready,
  output logic o_aw_valid,
  output logic o_w_valid,
  output logic o_done
);

  logic r_aw_done;
  logic r_w_done;
  logic w_aw_hs;
  logic w_w_hs;

  assign o_aw_valid = i_active && !r_aw_done;
  assign o_w_valid  = i_active && !r_w_done;
  assign w_aw_hs    = o_aw_valid && i_aw_ready;
  assign w_w_hs     = o_w_valid && i_w_ready;
  assign o_done     = i_active && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // Remember each accepted channel; clear once the pair completes or when idle
  always_ff @(posedge clk) begin
    if (rst || !i_active || o_done) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/lsu_axi_bridge.sv
// Converts single LSU load/store requests into single-beat 64-bit AXI4
// transactions, one outstanding at a time, with an active-low completion strobe.
import lsu_axi_bridge_pkg::*;

module lsu_axi_bridge #(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = LSU_DATA_W,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                re,
  input  logic                we,
  input  logic [63:0]         data_pc,
  input  logic [DATA_W-1:0]   data_o,
  input  logic [7:0]          wlen,
  input  logic                core_ready,
  output logic [DATA_W-1:0]   data_temp,
  output logic                data_valid,
  output logic                bus_err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [3:0]          ar_id,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [3:0]          aw_id,
  output logic [7:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [7:0]          w_strb,
  output logic                w_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_wstrb;
  logic                w_wr_active;
  logic                w_wr_done;

  // Single-beat, full-width transfers only; r_last is implied by the single beat.
  wire w_unused = &{1'b0, r_last, data_pc[63:ADDR_W]};

  assign ar_id    = AXI_ID;
  assign aw_id    = AXI_ID;
  assign ar_len   = 8'd0;
  assign aw_len   = 8'd0;
  assign ar_size  = SIZE_8B;
  assign aw_size  = SIZE_8B;
  assign ar_burst = BURST_INCR;
  assign aw_burst = BURST_INCR;
  assign w_last   = 1'b1;

  // Handshake signals decode straight from the state register so a reset
  // drops every valid on the same edge the state returns to IDLE.
  assign ar_valid   = (r_state == ST_RD_ADDR);
  assign r_ready    = (r_state == ST_RD_DATA);
  assign b_ready    = (r_state == ST_WR_RESP);
  assign data_valid = (r_state != ST_DONE);
  assign ar_addr    = r_addr;
  assign aw_addr    = r_addr;
  assign w_data     = r_wdata;
  assign w_strb     = r_wstrb;
  assign w_wr_active = (r_state == ST_WR_REQ);

  axi_wr_channel_ctl u_wr_ctl (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_wr_active),
    .i_aw_ready (aw_ready),
    .i_w_ready  (w_ready),
    .o_aw_valid (aw_valid),
    .o_w_valid  (w_valid),
    .o_done     (w_wr_done)
  );

  // Transaction sequencer: request capture, AXI phases, held completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      data_temp <= '0;
      bus_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (re) begin
            r_addr  <= data_pc[ADDR_W-1:0];
            r_state <= ST_RD_ADDR;
          end else if (we) begin
            r_addr  <= data_pc[ADDR_W-1:0];
            r_wdata <= data_o;
            r_wstrb <= wlen;
            r_state <= ST_WR_REQ;
          end
        end
        ST_RD_ADDR: if (ar_ready) r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (r_valid) begin
            data_temp <= r_data;
            bus_err   <= bus_err | (r_resp != RESP_OKAY);
            r_state   <= ST_DONE;
          end
        end
        ST_WR_REQ: if (w_wr_done) r_state <= ST_WR_RESP;
        ST_WR_RESP: begin
          if (b_valid) begin
            bus_err <= bus_err | (b_resp != RESP_OKAY);
            r_state <= ST_DONE;
          end
        end
        // IDLE after DONE guarantees a fresh resample of re/we
        ST_DONE: if (core_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge: zero-wait load, stalled store, held
// completion, SLVERR stickiness, back-to-back requests and mid-read reset.
module tb_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst, re, we, core_ready;
  logic [63:0] data_pc, data_o;
  logic [7:0]  wlen;
  logic [63:0] data_temp;
  logic        data_valid, bus_err;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [3:0]  ar_id, aw_id;
  logic [7:0]  ar_len, aw_len, w_strb;
  logic [2:0]  ar_size, aw_size;
  logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data, w_data;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic        b_valid, b_ready;

  int vectors = 0;
  int errs    = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  int ar_base, aw_base, w_base;

  always #5 clk = ~clk;

  lsu_axi_bridge dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .data_pc(data_pc), .data_o(data_o),
    .wlen(wlen), .core_ready(core_ready), .data_temp(data_temp),
    .data_valid(data_valid), .bus_err(bus_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  // Handshake counters used to detect duplicate transactions
  always @(posedge clk) begin
    if (ar_valid && ar_ready) ar_cnt <= ar_cnt + 1;
    if (aw_valid && aw_ready) aw_cnt <= aw_cnt + 1;
    if (w_valid && w_ready)   w_cnt  <= w_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Zero-wait load up to the DONE entry cycle
  task automatic load_to_done(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp);
    re = 1'b1; data_pc = a; step();
    re = 1'b0; ar_ready = 1'b1; step();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = d; r_resp = resp; step();
    r_valid = 1'b0; r_resp = 2'b00;
  endtask

  initial begin
    rst = 1'b1; re = 0; we = 0; core_ready = 1; data_pc = '0; data_o = '0; wlen = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = '0; r_last = 1;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    step(); step();

    // Reset state
    check("rst_data_valid", data_valid, 1);
    check("rst_valids", {ar_valid, aw_valid, w_valid, r_ready, b_ready}, 0);
    check("rst_data_temp", data_temp, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_addr", {ar_addr, aw_addr}, 0);
    rst = 1'b0;

    // T1: zero-wait load
    re = 1; data_pc = 64'h0000_0000_8000_0010; step();
    check("t1_ar_valid", ar_valid, 1);
    check("t1_ar_addr", ar_addr, 32'h8000_0010);
    check("t1_ar_const", {ar_id, ar_len, ar_size, ar_burst}, {4'd1, 8'd0, 3'b011, 2'b01});
    check("t1_dv_c1", data_valid, 1);
    re = 0; ar_ready = 1; step();
    check("t1_rd_data", {ar_valid, r_ready, data_valid}, 3'b011);
    ar_ready = 0; r_valid = 1; r_data = 64'h1122_3344_5566_7788; step();
    check("t1_dv_c3", data_valid, 0);
    check("t1_data_temp", data_temp, 64'h1122_3344_5566_7788);
    check("t1_r_ready_off", r_ready, 0);
    r_valid = 0; step();
    check("t1_dv_c4", data_valid, 1);

    // T2: store, aw_ready delayed 3 cycles, w_ready immediate
    we = 1; data_pc = 64'h8000_0020; data_o = 64'h0000_0000_ABCD_0000; wlen = 8'b0000_1100;
    w_ready = 1; step();
    check("t2_c1_valids", {aw_valid, w_valid}, 2'b11);
    check("t2_w_data", w_data, 64'h0000_0000_ABCD_0000);
    check("t2_w_strb", w_strb, 8'b0000_1100);
    check("t2_aw_const", {aw_id, aw_len, aw_size, aw_burst, w_last}, {4'd1, 8'd0, 3'b011, 2'b01, 1'b1});
    we = 0; data_o = '1; wlen = 8'hFF; data_pc = '1; step();
    w_ready = 0;
    check("t2_c2_valids", {aw_valid, w_valid}, 2'b10);
    check("t2_c2_aw_addr", aw_addr, 32'h8000_0020);
    step();
    check("t2_c3_valids", {aw_valid, w_valid, b_ready}, 3'b100);
    check("t2_c3_aw_addr", aw_addr, 32'h8000_0020);
    aw_ready = 1; step();
    aw_ready = 0;
    check("t2_wr_resp", {aw_valid, w_valid, b_ready, data_valid}, 4'b0011);
    b_valid = 1; step();
    b_valid = 0;
    check("t2_done", data_valid, 0);
    check("t2_data_temp_kept", data_temp, 64'h1122_3344_5566_7788);
    check("t2_bus_err", bus_err, 0);
    step();
    check("t2_idle", data_valid, 1);

    // T3: completion held while core_ready=0
    core_ready = 0;
    load_to_done(64'h8000_0040, 64'hCAFE_F00D_DEAD_BEEF, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_hold%0d_dv", i), data_valid, 0);
      check($sformatf("t3_hold%0d_dt", i), data_temp, 64'hCAFE_F00D_DEAD_BEEF);
      step();
    end
    core_ready = 1;
    check("t3_exit_cycle_dv", data_valid, 0);
    step();
    check("t3_exited", data_valid, 1);

    // T4: SLVERR sets sticky bus_err
    load_to_done(64'h8000_0050, 64'h0123_4567_89AB_CDEF, 2'b10);
    check("t4_bus_err", bus_err, 1);
    check("t4_data_temp", data_temp, 64'h0123_4567_89AB_CDEF);
    step();

    // T6: back-to-back load then store, re/we swap at completion edge
    ar_base = ar_cnt; aw_base = aw_cnt; w_base = w_cnt;
    ar_ready = 1; r_valid = 1; r_data = 64'h5555_AAAA_5555_AAAA;
    re = 1; data_pc = 64'h8000_0060; step();   // RD_ADDR
    step();                                     // RD_DATA
    step();                                     // DONE
    check("t6_ld_done", data_valid, 0);
    re = 0; we = 1; data_pc = 64'h8000_0068; data_o = 64'h1; wlen = 8'h01;
    aw_ready = 1; w_ready = 1; b_valid = 1; step();
    check("t6_idle_gap", {ar_valid, aw_valid, w_valid, data_valid}, 4'b0001);
    step();                                     // WR_REQ, both accepted at once
    check("t6_wr_req", {aw_valid, w_valid}, 2'b11);
    check("t6_aw_addr", aw_addr, 32'h8000_0068);
    we = 0; step();                             // WR_RESP
    check("t6_wr_resp", b_ready, 1);
    step();                                     // DONE
    check("t6_st_done", data_valid, 0);
    ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
    step(); step(); step();
    check("t6_ar_count", ar_cnt - ar_base, 1);
    check("t6_aw_count", aw_cnt - aw_base, 1);
    check("t6_w_count", w_cnt - w_base, 1);
    check("t6_bus_err_sticky", bus_err, 1);
    check("t6_data_temp", data_temp, 64'h5555_AAAA_5555_AAAA);

    // T5: reset while waiting in RD_DATA
    re = 1; data_pc = 64'h8000_0070; step();
    re = 0; ar_ready = 1; step();
    ar_ready = 0;
    check("t5_in_rd_data", r_ready, 1);
    rst = 1; step();
    rst = 0;
    check("t5_r_ready", r_ready, 0);
    check("t5_valids", {ar_valid, aw_valid, w_valid, b_ready}, 0);
    check("t5_data_valid", data_valid, 1);
    check("t5_data_temp", data_temp, 0);
    check("t5_bus_err", bus_err, 0);
    step();
    check("t5_stays_idle", {ar_valid, r_ready, data_valid}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
